// File: rtl/aurora_rx_block_sync_if.sv
// Lane-side signals of the Aurora 64b/66b block-sync controller.
// master drives sync headers; slave is the controller.
interface aurora_rx_block_sync_if;
  logic       header_valid_i;
  logic [1:0] header_i;
  logic       gearbox_slip_o;
  logic       serdes_slip_o;
  logic       block_lock_o;
  logic [6:0] slip_count_o;
  logic [7:0] serdes_slip_count_o;
  logic [7:0] lock_loss_count_o;

  modport master (
    output header_valid_i, header_i,
    input  gearbox_slip_o, serdes_slip_o, block_lock_o,
    input  slip_count_o, serdes_slip_count_o, lock_loss_count_o
  );

  modport slave (
    input  header_valid_i, header_i,
    output gearbox_slip_o, serdes_slip_o, block_lock_o,
    output slip_count_o, serdes_slip_count_o, lock_loss_count_o
  );
endinterface

// File: rtl/aurora_rx_block_sync.sv
// Aurora 64b/66b receive block synchronisation: hunts for header alignment,
// issues gearbox/SERDES slips, and monitors header error rate while locked.
module aurora_rx_block_sync #(
  parameter int unsigned LOCK_COUNT = 32,
  parameter int unsigned ERR_WINDOW = 64,
  parameter int unsigned ERR_MAX    = 16,
  parameter int unsigned SLIP_WAIT  = 16,
  parameter int unsigned GBOX_SLIPS = 66
) (
  input  logic                   clk_rx_i,
  input  logic                   rst_n_i,
  aurora_rx_block_sync_if.slave  lane
);
  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WW = $clog2(ERR_WINDOW + 1);
  localparam int unsigned EW = $clog2(ERR_MAX + 1);
  localparam int unsigned TW = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {S_HUNT, S_SLIP, S_WAIT, S_LOCKED} state_t;

  state_t      r_state, w_state_nxt;
  logic [GW-1:0] r_good_cnt, w_good_cnt_nxt;
  logic [WW-1:0] r_win_cnt,  w_win_cnt_nxt;
  logic [EW-1:0] r_err_cnt,  w_err_cnt_nxt;
  logic [TW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [6:0]  r_slip_cnt, w_slip_cnt_nxt;
  logic [7:0]  r_serdes_cnt, w_serdes_cnt_nxt;
  logic [7:0]  r_loss_cnt, w_loss_cnt_nxt;
  logic        r_lock, w_lock_nxt;
  logic        r_gslip, w_gslip_nxt;
  logic        r_sslip, w_sslip_nxt;
  logic        w_hdr_ok;
  logic        w_go_slip;

  assign w_hdr_ok = lane.header_i[1] ^ lane.header_i[0];

  always_comb begin
    w_state_nxt      = r_state;
    w_good_cnt_nxt   = r_good_cnt;
    w_win_cnt_nxt    = r_win_cnt;
    w_err_cnt_nxt    = r_err_cnt;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_slip_cnt_nxt   = r_slip_cnt;
    w_serdes_cnt_nxt = r_serdes_cnt;
    w_loss_cnt_nxt   = r_loss_cnt;
    w_lock_nxt       = r_lock;
    w_gslip_nxt      = 1'b0;
    w_sslip_nxt      = 1'b0;
    w_go_slip        = 1'b0;

    case (r_state)
      S_HUNT: begin
        if (lane.header_valid_i) begin
          if (w_hdr_ok) begin
            w_good_cnt_nxt = r_good_cnt + GW'(1);
            if (r_good_cnt == GW'(LOCK_COUNT - 1)) begin
              w_state_nxt    = S_LOCKED;
              w_lock_nxt     = 1'b1;
              w_slip_cnt_nxt = '0;
              w_win_cnt_nxt  = '0;
              w_err_cnt_nxt  = '0;
            end
          end else begin
            w_good_cnt_nxt = '0;
            w_go_slip      = 1'b1;
          end
        end
      end
      S_SLIP: begin
        w_state_nxt    = S_WAIT;
        w_wait_cnt_nxt = '0;
      end
      S_WAIT: begin
        if (r_wait_cnt == TW'(SLIP_WAIT - 1)) begin
          w_state_nxt    = S_HUNT;
          w_wait_cnt_nxt = '0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + TW'(1);
        end
      end
      S_LOCKED: begin
        if (lane.header_valid_i) begin
          w_win_cnt_nxt = r_win_cnt + WW'(1);
          if (!w_hdr_ok)
            w_err_cnt_nxt = r_err_cnt + EW'(1);
          // lock loss takes priority over the end-of-window clear
          if (!w_hdr_ok && r_err_cnt == EW'(ERR_MAX - 1)) begin
            w_lock_nxt     = 1'b0;
            w_good_cnt_nxt = '0;
            w_go_slip      = 1'b1;
            if (r_loss_cnt != '1)
              w_loss_cnt_nxt = r_loss_cnt + 8'd1;
          end else if (r_win_cnt == WW'(ERR_WINDOW - 1)) begin
            w_win_cnt_nxt = '0;
            w_err_cnt_nxt = '0;
          end
        end
      end
      default: w_state_nxt = S_HUNT;
    endcase

    // slip decision is registered on entry to SLIP so the pulse occupies the SLIP cycle
    if (w_go_slip) begin
      w_state_nxt = S_SLIP;
      if (r_slip_cnt == 7'(GBOX_SLIPS - 1)) begin
        w_sslip_nxt    = 1'b1;
        w_slip_cnt_nxt = '0;
        if (r_serdes_cnt != '1)
          w_serdes_cnt_nxt = r_serdes_cnt + 8'd1;
      end else begin
        w_gslip_nxt    = 1'b1;
        w_slip_cnt_nxt = r_slip_cnt + 7'd1;
      end
    end
  end

  always_ff @(posedge clk_rx_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_HUNT;
      r_good_cnt   <= '0;
      r_win_cnt    <= '0;
      r_err_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_slip_cnt   <= '0;
      r_serdes_cnt <= '0;
      r_loss_cnt   <= '0;
      r_lock       <= 1'b0;
      r_gslip      <= 1'b0;
      r_sslip      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_good_cnt   <= w_good_cnt_nxt;
      r_win_cnt    <= w_win_cnt_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_slip_cnt   <= w_slip_cnt_nxt;
      r_serdes_cnt <= w_serdes_cnt_nxt;
      r_loss_cnt   <= w_loss_cnt_nxt;
      r_lock       <= w_lock_nxt;
      r_gslip      <= w_gslip_nxt;
      r_sslip      <= w_sslip_nxt;
    end
  end

  assign lane.gearbox_slip_o      = r_gslip;
  assign lane.serdes_slip_o       = r_sslip;
  assign lane.block_lock_o        = r_lock;
  assign lane.slip_count_o        = r_slip_cnt;
  assign lane.serdes_slip_count_o = r_serdes_cnt;
  assign lane.lock_loss_count_o   = r_loss_cnt;
endmodule

// File: tb/tb_aurora_rx_block_sync.sv
// Directed self-checking bench for aurora_rx_block_sync; a second instance with
// small slip parameters exercises SERDES-slip counter saturation.
module tb_aurora_rx_block_sync;
  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  int k, last, both, pulses, drops, k2;

  aurora_rx_block_sync_if lane();
  aurora_rx_block_sync_if lane2();

  aurora_rx_block_sync #(
    .LOCK_COUNT(32), .ERR_WINDOW(64), .ERR_MAX(16), .SLIP_WAIT(16), .GBOX_SLIPS(66)
  ) dut (
    .clk_rx_i(clk), .rst_n_i(rst_n), .lane(lane)
  );

  aurora_rx_block_sync #(
    .LOCK_COUNT(32), .ERR_WINDOW(64), .ERR_MAX(16), .SLIP_WAIT(1), .GBOX_SLIPS(2)
  ) dut_sat (
    .clk_rx_i(clk), .rst_n_i(rst2_n), .lane(lane2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {6'd0, lane.gearbox_slip_o, lane.serdes_slip_o, lane.block_lock_o,
              lane.slip_count_o, lane.serdes_slip_count_o, lane.lock_loss_count_o}, 32'd0);
  endtask

  // Present one header, then step to 1 time unit past the sampling edge.
  task automatic cyc(input logic v, input logic [1:0] h);
    lane.header_valid_i = v;
    lane.header_i       = h;
    @(posedge clk);
    #1;
  endtask

  task automatic lock_seq(input string tag, input logic [1:0] h);
    int p;
    p = 0;
    for (int i = 0; i < 31; i++) begin
      cyc(1'b1, h);
      p += int'(lane.gearbox_slip_o) + int'(lane.serdes_slip_o);
    end
    chk({tag, "_lock31"}, lane.block_lock_o, 0);
    cyc(1'b1, h);
    chk({tag, "_lock32"}, lane.block_lock_o, 1);
    chk({tag, "_noslip"}, p, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rst2_n = 1'b0;
    lane.header_valid_i  = 1'b0;
    lane.header_i        = 2'b00;
    lane2.header_valid_i = 1'b1;
    lane2.header_i       = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    rst_n = 1'b1;
    lock_seq("plain", 2'b01);

    // window with 15 errors holds lock
    drops = 0;
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, (i < 15) ? ((i % 2 != 0) ? 2'b11 : 2'b00) : 2'b01);
      drops += int'(!lane.block_lock_o);
    end
    chk("win15_hold", drops, 0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'b10);
    for (int i = 0; i < 15; i++) cyc(1'b1, 2'b00);
    chk("win16_pre", lane.block_lock_o, 1);
    cyc(1'b1, 2'b11);
    chk("win16_lock", lane.block_lock_o, 0);
    chk("win16_gslip", lane.gearbox_slip_o, 1);
    chk("win16_loss", lane.lock_loss_count_o, 1);
    chk("win16_slipcnt", lane.slip_count_o, 1);

    // relock: 17 ignored cycles (SLIP + WAIT) then 32 valid
    cyc(1'b1, 2'b01);
    chk("gslip_1cyc", lane.gearbox_slip_o, 0);
    for (int i = 0; i < 47; i++) cyc(1'b1, 2'b01);
    chk("relock_pre", lane.block_lock_o, 0);
    cyc(1'b1, 2'b01);
    chk("relock", lane.block_lock_o, 1);
    chk("relock_slipcnt", lane.slip_count_o, 0);

    // 64th header is also the 16th error
    for (int i = 0; i < 48; i++) cyc(1'b1, 2'b01);
    for (int i = 0; i < 15; i++) cyc(1'b1, 2'b00);
    chk("simul_pre", lane.block_lock_o, 1);
    cyc(1'b1, 2'b11);
    chk("simul_lock", lane.block_lock_o, 0);
    chk("simul_loss", lane.lock_loss_count_o, 2);
    chk("simul_gslip", lane.gearbox_slip_o, 1);

    // reset during the slip pulse, no clock edge in between
    rst_n = 1'b0;
    #2;
    chk_zero("rst_mid_slip");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single gearbox slip
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'b01);
    cyc(1'b1, 2'b00);
    chk("gs_pulse", lane.gearbox_slip_o, 1);
    chk("gs_serdes", lane.serdes_slip_o, 0);
    chk("gs_slipcnt", lane.slip_count_o, 1);
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 2'b11);
      pulses += int'(lane.gearbox_slip_o) + int'(lane.serdes_slip_o);
    end
    chk("gs_ignored", pulses, 0);
    chk("gs_slipcnt_hold", lane.slip_count_o, 1);
    lock_seq("gs_lock", 2'b10);
    chk("gs_lock_slipcnt", lane.slip_count_o, 0);

    // reset in the middle of WAIT
    rst_n = 1'b0;
    #2;
    chk_zero("rst_locked");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 2'b00);
    chk("w_gslip", lane.gearbox_slip_o, 1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 2'b01);
    chk("w_slipcnt", lane.slip_count_o, 1);
    rst_n = 1'b0;
    #2;
    chk_zero("rst_mid_wait");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lock_seq("after_wait_rst", 2'b01);

    // continuous bad headers: 65 gearbox slips then one SERDES slip, periodic
    rst_n = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0; last = 0; both = 0;
    for (int c = 1; c <= 3000 && k < 132; c++) begin
      cyc(1'b1, 2'b11);
      both += int'(lane.gearbox_slip_o & lane.serdes_slip_o);
      if (lane.gearbox_slip_o || lane.serdes_slip_o) begin
        k++;
        if (k == 1) chk("ss_first", c, 1);
        else        chk("ss_gap", c - last, 18);
        last = c;
        if (k % 66 == 0) begin
          chk("ss_is_serdes", lane.serdes_slip_o, 1);
          chk("ss_slipcnt0", lane.slip_count_o, 0);
          chk("ss_serdescnt", lane.serdes_slip_count_o, k / 66);
        end else begin
          chk("ss_is_gbox", lane.gearbox_slip_o, 1);
          chk("ss_slipcnt", lane.slip_count_o, k % 66);
        end
      end
    end
    chk("ss_pulses", k, 132);
    chk("ss_excl", both, 0);

    // saturation on the small-parameter instance
    rst2_n = 1'b1;
    k2 = 0;
    for (int c = 0; c < 2500 && k2 < 300; c++) begin
      @(posedge clk);
      #1;
      if (lane2.serdes_slip_o) begin
        k2++;
        chk("sat_cnt", lane2.serdes_slip_count_o, (k2 > 255) ? 255 : k2);
      end
    end
    chk("sat_pulses", k2, 300);
    chk("sat_final", lane2.serdes_slip_count_o, 255);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/aurora_rx_block_sync.md
# aurora_rx_block_sync

Block-synchronisation controller for the Aurora 64b/66b receive lane. It watches the 2-bit sync headers from the lane gearbox and declares block lock after enough consecutive valid headers. Without lock it sequences alignment search by pulsing the gearbox slip, and after a full 66-position sweep it pulses the SERDES bit slip. While locked it tracks the header error rate and drops lock when errors exceed the threshold.

## Interface
Parameters:
- LOCK_COUNT, 32: consecutive valid headers in HUNT needed to declare lock (≥1).
- ERR_WINDOW, 64: headers per error-monitoring window while locked.
- ERR_MAX, 16: invalid headers within one window that cause lock loss (1..ERR_WINDOW).
- SLIP_WAIT, 16: cycles after a slip pulse during which headers are ignored (≥1).
- GBOX_SLIPS, 66: slip count that triggers a SERDES slip instead of a gearbox slip (≥2).

Ports:
- clk_rx_i  in  1  lane receive clock; the only clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- header_valid_i  in  1  new block header present on header_i this cycle.
- header_i  in  2  sync header; 2'b01 and 2'b10 are valid, 2'b00 and 2'b11 are invalid.
- gearbox_slip_o  out  1  one-cycle pulse; gearbox shifts alignment by one bit.
- serdes_slip_o  out  1  one-cycle pulse; SERDES performs a bit slip.
- block_lock_o  out  1  block lock achieved.
- slip_count_o  out  7  slips issued since the last lock or SERDES slip.
- serdes_slip_count_o  out  8  SERDES slips since reset; saturates at 255.
- lock_loss_count_o  out  8  lock-loss events since reset; saturates at 255.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset state is HUNT, and all internal counters reset to 0.
- header_i is sampled only when header_valid_i=1.
- **HUNT**
  - Valid header: good_cnt++. When good_cnt reaches LOCK_COUNT, go to LOCKED, clear slip_count, and clear the window and error counters.
  - Invalid header: clear good_cnt and go to SLIP.
- **SLIP** (lasts exactly 1 cycle)
  - If slip_count == GBOX_SLIPS-1: assert serdes_slip_o, set slip_count to 0, and increment serdes_slip_count (saturating).
  - Otherwise: assert gearbox_slip_o and increment slip_count.
  - Next state is WAIT.
- **WAIT**
  - Run wait_cnt from 0 to SLIP_WAIT-1, then go to HUNT.
  - All headers arriving during WAIT are discarded and affect no counter.
- **LOCKED**
  - Each sampled header increments win_cnt. Each invalid header also increments err_cnt.
  - If err_cnt reaches ERR_MAX: clear block_lock_o, increment lock_loss_count (saturating), clear good_cnt, and go to SLIP.
  - Otherwise, if win_cnt reaches ERR_WINDOW: clear win_cnt and err_cnt, and stay in LOCKED.
  - If the same header both completes the window and reaches ERR_MAX, lock loss wins.
- The gearbox_slip_o and serdes_slip_o pulses are mutually exclusive and are never both high in the same cycle.
- Internal counter widths are $clog2(param+1). Counts never wrap; each counter is cleared explicitly as described above.

## Timing
- Header sampled at edge N drives the state update at edge N; registered outputs reflect it during cycle N+1.
- block_lock_o:
  - Rises in the cycle after the LOCK_COUNT-th consecutive valid header is sampled.
  - Falls in the cycle after the ERR_MAX-th invalid header in a window is sampled.
- Slip pulse: an invalid header sampled in cycle N (HUNT or LOCKED lock-loss) produces the pulse in cycle N+1, high for exactly 1 cycle.
- WAIT occupies cycles N+2 .. N+1+SLIP_WAIT. The first header that can be sampled arrives in cycle N+2+SLIP_WAIT.
- Minimum spacing between slip pulses: SLIP_WAIT+2 cycles.
- Fastest lock from reset is LOCK_COUNT cycles with header_valid_i held high.
- Asserting rst_n_i in any state clears all outputs immediately, without waiting for a clock edge. A slip pulse in progress is truncated.

## Test plan
- **Reset:** hold rst_n_i=0 → all outputs 0. Release and apply 31 headers 2'b01 → block_lock_o stays 0. The 32nd header → block_lock_o=1 on the next cycle, and no slip pulse occurs.
- **Single gearbox slip:** from reset, 5×2'b01 then 2'b00 → gearbox_slip_o high for exactly 1 cycle (the cycle after the 2'b00) and slip_count_o=1. A 2'b11 fed in the following 16 cycles is ignored. Then 32×2'b10 → lock, and slip_count_o=0.
- **SERDES slip:** header_i=2'b11 held continuously → 65 gearbox_slip_o pulses spaced 18 cycles apart, then 1 serdes_slip_o pulse. After it, slip_count_o=0 and serdes_slip_count_o=1. The cycle stays periodic with 66 pulses per SERDES slip.
- **Error window:** when locked, a 64-header window containing 15 invalid headers → lock is held and counters clear at the window end. In the next window, 16 invalid headers → block_lock_o falls the cycle after the 16th, lock_loss_count_o=1, and gearbox_slip_o pulses in that same cycle.
- **Simultaneous events:** the 64th header of a window is the 16th invalid one → lock is lost (not held).
- **Reset mid-operation:** assert rst_n_i low in the middle of WAIT, and separately in the middle of a slip pulse → all outputs go to 0 with no clock edge. After release, behaviour matches the plain reset case.
- **Saturation:** force 300 SERDES slips → serdes_slip_count_o=255 and does not wrap.
